if_id_pipe_reg: RTL and testbench

IF_ID_PIPE_REG -- requirements
Module: if_id_pipe_reg

---
 rtl/pipe_pkg.sv | 53 +++++
 rtl/instruction_fields.sv | 42 ++++
 rtl/if_id_pipe_reg.sv | 189 ++++++++++++++++++
 tb/tb_if_id_pipe_reg.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// -----------------------------------------------------------------------------
// pipe_pkg
//
// Purpose : Constants and types shared by the IF/ID pipeline register and its
//           field-extraction sub-module. Holds the MIPS-style opcode values,
//           the instruction field widths and the decoded-instruction struct
//           that travels through the buffer entries.
//
// Contents:
//   OPC_*        primary opcode values (OPC_LUI selects upper-half immediate)
//   *_W          field widths of a 32-bit instruction word
//   decoded_t    packed struct: opcode, rs, rt, rd, imm, funct, pc4, extend_side
//   occ_e        buffer occupancy encoding (empty / main only / main + skid)
// -----------------------------------------------------------------------------
package pipe_pkg;

   // Instruction field widths
   localparam int WORD_W   = 32;
   localparam int OPCODE_W = 6;
   localparam int REG_W    = 5;
   localparam int IMM_W    = 16;
   localparam int FUNCT_W  = 6;

   // Primary opcodes
   localparam logic [OPCODE_W-1:0] OPC_RTYPE = 6'h00;
   localparam logic [OPCODE_W-1:0] OPC_J     = 6'h02;
   localparam logic [OPCODE_W-1:0] OPC_BEQ   = 6'h04;
   localparam logic [OPCODE_W-1:0] OPC_ADDI  = 6'h08;
   localparam logic [OPCODE_W-1:0] OPC_LUI   = 6'h0F;
   localparam logic [OPCODE_W-1:0] OPC_LW    = 6'h23;
   localparam logic [OPCODE_W-1:0] OPC_SW    = 6'h2B;

   // One decoded instruction as stored in a buffer entry. rd, imm and funct
   // overlap in the raw word; decode picks whichever it needs downstream.
   typedef struct packed {
      logic [OPCODE_W-1:0] opcode;
      logic [REG_W-1:0]    rs;
      logic [REG_W-1:0]    rt;
      logic [REG_W-1:0]    rd;
      logic [IMM_W-1:0]    imm;
      logic [FUNCT_W-1:0]  funct;
      logic [WORD_W-1:0]   pc4;
      logic                extend_side;
   } decoded_t;

   // Buffer occupancy: main entry only, or main plus skid entry
   typedef enum logic [1:0] {
      OCC_EMPTY = 2'd0,
      OCC_ONE   = 2'd1,
      OCC_FULL  = 2'd2
   } occ_e;

endpackage : pipe_pkg

// File: rtl/instruction_fields.sv
// -----------------------------------------------------------------------------
// instruction_fields
//
// Purpose : Purely combinational split of a 32-bit instruction word into its
//           fields, plus the ExtendSide flag (upper-half immediate placement
//           for LUI). The flag is derived here, on the input path, so it is
//           stored alongside the rest of the entry rather than recomputed at
//           the output.
//
// Parameters:
//   LUI_OPCODE  opcode that sets extend_side
//
// Ports:
//   i_word    in   32  instruction word
//   i_pc4     in   32  fetch PC + 4 belonging to i_word
//   o_fields  out  decoded_t  extracted fields, pc4 and extend_side
// -----------------------------------------------------------------------------
module instruction_fields
   import pipe_pkg::*;
#(
   parameter logic [OPCODE_W-1:0] LUI_OPCODE = OPC_LUI
) (
   input  logic [WORD_W-1:0] i_word,
   input  logic [WORD_W-1:0] i_pc4,
   output decoded_t          o_fields
);

   always_comb begin
      // NOTE: every combinational output gets a default first so no path can
      // leave it unassigned and infer a latch.
      o_fields             = '0;
      o_fields.opcode      = i_word[31:26];
      o_fields.rs          = i_word[25:21];
      o_fields.rt          = i_word[20:16];
      o_fields.rd          = i_word[15:11];
      o_fields.imm         = i_word[15:0];
      o_fields.funct       = i_word[5:0];
      o_fields.pc4         = i_pc4;
      o_fields.extend_side = (i_word[31:26] == LUI_OPCODE);
   end

endmodule : instruction_fields

// File: rtl/if_id_pipe_reg.sv
// -----------------------------------------------------------------------------
// if_id_pipe_reg
//
// Purpose : IF/ID pipeline register built as a two-entry skid buffer. The
//           main entry drives every output; the skid entry absorbs the one
//           word that fetch may push in the cycle decode stalls, so in_ready
//           can be a flop that never looks at out_ready.
//
// Configuration:
//   IFID_FLUSH_EN  when defined, adds the Flush input, which empties both
//                  entries, zeroes the field outputs and drops a same-cycle
//                  input transfer. Undefined: no Flush port or logic.
//
// Parameters:
//   LUI_OPCODE  opcode that sets ExtendSide (default 6'h0F)
//   DEPTH       number of entries; only 2 (main + skid) is supported
//
// Ports:
//   clk          in   1   clock, rising edge
//   reset        in   1   synchronous active-high reset
//   in_valid     in   1   fetch offers Instruction / PC_4
//   in_ready     out  1   registered: skid entry empty
//   Instruction  in   32  fetched word
//   PC_4         in   32  fetch PC + 4
//   Flush        in   1   discard buffered words (IFID_FLUSH_EN only)
//   out_valid    out  1   head entry present
//   out_ready    in   1   decode consumes the head entry
//   Opcode       out  6   head Instruction[31:26]
//   Rs/Rt/Rd     out  5   head Instruction[25:21] / [20:16] / [15:11]
//   Immediate    out  16  head Instruction[15:0]
//   Funct        out  6   head Instruction[5:0]
//   ExtendSide   out  1   head opcode == LUI_OPCODE
//   PC_4_out     out  32  head PC_4
// -----------------------------------------------------------------------------
module if_id_pipe_reg
   import pipe_pkg::*;
#(
   parameter logic [OPCODE_W-1:0] LUI_OPCODE = OPC_LUI,
   parameter int                  DEPTH      = 2
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic [WORD_W-1:0]   Instruction,
   input  logic [WORD_W-1:0]   PC_4,
`ifdef IFID_FLUSH_EN
   input  logic                Flush,
`endif
   output logic                out_valid,
   input  logic                out_ready,
   output logic [OPCODE_W-1:0] Opcode,
   output logic [FUNCT_W-1:0]  Funct,
   output logic [REG_W-1:0]    Rs,
   output logic [REG_W-1:0]    Rt,
   output logic [REG_W-1:0]    Rd,
   output logic [IMM_W-1:0]    Immediate,
   output logic                ExtendSide,
   output logic [WORD_W-1:0]   PC_4_out
);

   // The occupancy logic below is written for exactly main + skid.
   if (DEPTH != 2) begin : g_depth_check
      $error("if_id_pipe_reg: only DEPTH = 2 is supported");
   end

   // ---------------------------------------------------------------------------
   // Field extraction on the input path
   // ---------------------------------------------------------------------------
   decoded_t w_in_entry;

   instruction_fields #(
      .LUI_OPCODE (LUI_OPCODE)
   ) u_fields (
      .i_word   (Instruction),
      .i_pc4    (PC_4),
      .o_fields (w_in_entry)
   );

   // ---------------------------------------------------------------------------
   // State
   // ---------------------------------------------------------------------------
   occ_e     r_occ;
   occ_e     w_occ_nxt;
   decoded_t r_main;
   decoded_t r_skid;
   decoded_t w_main_nxt;
   decoded_t w_skid_nxt;
   logic     r_in_ready;
   logic     r_out_valid;

   logic     w_push;
   logic     w_pop;

   assign w_push = in_valid  && r_in_ready;
   assign w_pop  = r_out_valid && out_ready;

   // ---------------------------------------------------------------------------
   // Next-state: occupancy and entry contents
   // ---------------------------------------------------------------------------
   always_comb begin
      w_occ_nxt  = r_occ;
      w_main_nxt = r_main;
      w_skid_nxt = r_skid;

      case (r_occ)
         OCC_EMPTY: begin
            if (w_push) begin
               w_main_nxt = w_in_entry;
               w_occ_nxt  = OCC_ONE;
            end
         end

         OCC_ONE: begin
            if (w_push && w_pop) begin
               // Head leaves while the new word takes its place.
               w_main_nxt = w_in_entry;
            end else if (w_push) begin
               w_skid_nxt = w_in_entry;
               w_occ_nxt  = OCC_FULL;
            end else if (w_pop) begin
               // Main keeps its contents so the outputs hold their last values.
               w_occ_nxt = OCC_EMPTY;
            end
         end

         OCC_FULL: begin
            // in_ready is low here, so only a pop can happen.
            if (w_pop) begin
               w_main_nxt = r_skid;
               w_occ_nxt  = OCC_ONE;
            end
         end

         default: begin
            w_occ_nxt = OCC_EMPTY;
         end
      endcase

`ifdef IFID_FLUSH_EN
      // Flush overrides any transfer decided above, including a push.
      if (Flush) begin
         w_occ_nxt  = OCC_EMPTY;
         w_main_nxt = '0;
         w_skid_nxt = '0;
      end
`endif
   end

   // ---------------------------------------------------------------------------
   // Registers
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so every flop
      // samples the pre-edge values of the others.
      if (reset) begin
         // NOTE: the entry payloads are reset too, not just the valid state,
         // because the field outputs must read 0 after reset.
         r_occ       <= OCC_EMPTY;
         r_main      <= '0;
         r_skid      <= '0;
         r_in_ready  <= 1'b1;
         r_out_valid <= 1'b0;
      end else begin
         r_occ       <= w_occ_nxt;
         r_main      <= w_main_nxt;
         r_skid      <= w_skid_nxt;
         // Handshake flags are flopped from the next occupancy so neither
         // depends combinationally on out_ready.
         r_in_ready  <= (w_occ_nxt != OCC_FULL);
         r_out_valid <= (w_occ_nxt != OCC_EMPTY);
      end
   end

   // ---------------------------------------------------------------------------
   // Outputs: all fields come from the main entry only
   // ---------------------------------------------------------------------------
   assign in_ready   = r_in_ready;
   assign out_valid  = r_out_valid;
   assign Opcode     = r_main.opcode;
   assign Funct      = r_main.funct;
   assign Rs         = r_main.rs;
   assign Rt         = r_main.rt;
   assign Rd         = r_main.rd;
   assign Immediate  = r_main.imm;
   assign ExtendSide = r_main.extend_side;
   assign PC_4_out   = r_main.pc4;

endmodule : if_id_pipe_reg

// File: tb/tb_if_id_pipe_reg.sv
// -----------------------------------------------------------------------------
// tb_if_id_pipe_reg
//
// Purpose : Self-checking bench for if_id_pipe_reg. A table of directed
//           vectors covers idle, streaming, backpressure and simultaneous
//           push/pop; hand-written sequences cover reset mid-stream and, when
//           IFID_FLUSH_EN is defined, Flush.
// -----------------------------------------------------------------------------
module tb_if_id_pipe_reg;

   logic        clk;
   logic        reset;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] instruction;
   logic [31:0] pc_4;
`ifdef IFID_FLUSH_EN
   logic        flush;
`endif
   logic        out_valid;
   logic        out_ready;
   logic [5:0]  opcode;
   logic [5:0]  funct;
   logic [4:0]  rs;
   logic [4:0]  rt;
   logic [4:0]  rd;
   logic [15:0] immediate;
   logic        extend_side;
   logic [31:0] pc_4_out;

   int total = 0;
   int bad   = 0;

   if_id_pipe_reg dut (
      .clk         (clk),
      .reset       (reset),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .Instruction (instruction),
      .PC_4        (pc_4),
`ifdef IFID_FLUSH_EN
      .Flush       (flush),
`endif
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .Opcode      (opcode),
      .Funct       (funct),
      .Rs          (rs),
      .Rt          (rt),
      .Rd          (rd),
      .Immediate   (immediate),
      .ExtendSide  (extend_side),
      .PC_4_out    (pc_4_out)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Test words
   localparam logic [31:0] W_A = 32'h2008_0005; // addi $t0,$zero,5
   localparam logic [31:0] W_B = 32'h3C01_1234; // lui  $at,0x1234
   localparam logic [31:0] W_C = 32'h0128_5020; // add  $t2,$t1,$t0
   localparam logic [31:0] W_D = 32'h8D09_0004; // lw   $t1,4($t0)
   localparam logic [31:0] W_E = 32'h3C1F_FFFF; // lui  $ra,0xFFFF

   typedef struct {
      logic        iv;
      logic [31:0] instr;
      logic [31:0] pc4;
      logic        ordy;
      logic        e_ov;
      logic        e_ir;
      logic [31:0] e_word;
      logic        e_ext;
      logic [31:0] e_pc4;
   } vec_t;

   localparam int N_VEC = 15;
   vec_t vecs[N_VEC];

   function automatic vec_t mk(input logic iv, input logic [31:0] instr,
                               input logic [31:0] pc4, input logic ordy,
                               input logic e_ov, input logic e_ir,
                               input logic [31:0] e_word, input logic e_ext,
                               input logic [31:0] e_pc4);
      vec_t v;
      v.iv = iv; v.instr = instr; v.pc4 = pc4; v.ordy = ordy;
      v.e_ov = e_ov; v.e_ir = e_ir; v.e_word = e_word;
      v.e_ext = e_ext; v.e_pc4 = e_pc4;
      return v;
   endfunction

   // Expected {Opcode,Rs,Rt,Rd,Funct,Immediate} for a given head word.
   function automatic logic [43:0] fields_of(input logic [31:0] w);
      return {w[31:26], w[25:21], w[20:16], w[15:11], w[5:0], w[15:0]};
   endfunction

   task automatic check(input string name, input logic [63:0] got,
                        input logic [63:0] want);
      total++;
      if (got !== want) begin
         bad++;
         $display("FAIL %s: got %h want %h", name, got, want);
      end
   endtask

   task automatic check_out(input string tag, input logic e_ov, input logic e_ir,
                            input logic [31:0] e_word, input logic e_ext,
                            input logic [31:0] e_pc4);
      check({tag, " out_valid"},  64'(out_valid),   64'(e_ov));
      check({tag, " in_ready"},   64'(in_ready),    64'(e_ir));
      check({tag, " fields"},
            64'({opcode, rs, rt, rd, funct, immediate}), 64'(fields_of(e_word)));
      check({tag, " ExtendSide"}, 64'(extend_side), 64'(e_ext));
      check({tag, " PC_4_out"},   64'(pc_4_out),    64'(e_pc4));
   endtask

   // Drive one cycle of inputs and sample just after the rising edge.
   task automatic step(input logic iv, input logic [31:0] instr,
                       input logic [31:0] pc4, input logic ordy);
      @(negedge clk);
      in_valid    = iv;
      instruction = instr;
      pc_4        = pc4;
      out_ready   = ordy;
      @(posedge clk);
      #1;
   endtask

   initial begin
      reset       = 1'b1;
      in_valid    = 1'b0;
      instruction = '0;
      pc_4        = '0;
      out_ready   = 1'b0;
`ifdef IFID_FLUSH_EN
      flush       = 1'b0;
`endif

      // iv  instr  pc4      ordy  ov  ir  head  ext  pc4_out
      // Idle then stream A, B with decode always ready
      vecs[0]  = mk(0, '0,  32'h00, 1,   0,  1,  '0,  0,   32'h00);
      vecs[1]  = mk(1, W_A, 32'h04, 1,   1,  1,  W_A, 0,   32'h04);
      vecs[2]  = mk(1, W_B, 32'h08, 1,   1,  1,  W_B, 1,   32'h08);
      vecs[3]  = mk(0, '0,  32'h00, 1,   0,  1,  W_B, 1,   32'h08);
      // Backpressure: A, B accepted, C held until decode releases
      vecs[4]  = mk(1, W_A, 32'h10, 0,   1,  1,  W_A, 0,   32'h10);
      vecs[5]  = mk(1, W_B, 32'h14, 0,   1,  0,  W_A, 0,   32'h10);
      vecs[6]  = mk(1, W_C, 32'h18, 0,   1,  0,  W_A, 0,   32'h10);
      vecs[7]  = mk(1, W_C, 32'h18, 0,   1,  0,  W_A, 0,   32'h10);
      vecs[8]  = mk(1, W_C, 32'h18, 1,   1,  1,  W_B, 1,   32'h14);
      vecs[9]  = mk(1, W_C, 32'h18, 1,   1,  1,  W_C, 0,   32'h18);
      vecs[10] = mk(0, '0,  32'h00, 1,   0,  1,  W_C, 0,   32'h18);
      // Simultaneous push/pop at occupancy 1
      vecs[11] = mk(1, W_D, 32'h20, 0,   1,  1,  W_D, 0,   32'h20);
      vecs[12] = mk(1, W_E, 32'h24, 1,   1,  1,  W_E, 1,   32'h24);
      vecs[13] = mk(0, '0,  32'h00, 0,   1,  1,  W_E, 1,   32'h24);
      vecs[14] = mk(0, '0,  32'h00, 1,   0,  1,  W_E, 1,   32'h24);

      // Reset state
      repeat (2) @(posedge clk);
      #1;
      check_out("reset", 1'b0, 1'b1, '0, 1'b0, '0);
      @(negedge clk);
      reset = 1'b0;

      for (int i = 0; i < N_VEC; i++) begin
         step(vecs[i].iv, vecs[i].instr, vecs[i].pc4, vecs[i].ordy);
         check_out($sformatf("v%0d", i), vecs[i].e_ov, vecs[i].e_ir,
                   vecs[i].e_word, vecs[i].e_ext, vecs[i].e_pc4);
      end

      // Reset mid-stream at occupancy 2 with a word on offer
      step(1'b1, W_D, 32'h30, 1'b0);
      step(1'b1, W_A, 32'h34, 1'b0);
      check_out("pre_reset", 1'b1, 1'b0, W_D, 1'b0, 32'h30);
      reset = 1'b1;
      step(1'b1, W_C, 32'h38, 1'b1);
      check_out("mid_reset", 1'b0, 1'b1, '0, 1'b0, '0);
      reset = 1'b0;
      step(1'b0, '0, 32'h0, 1'b1);
      check_out("post_reset", 1'b0, 1'b1, '0, 1'b0, '0);

`ifdef IFID_FLUSH_EN
      // Flush at occupancy 2 with a word on offer
      step(1'b1, W_A, 32'h40, 1'b0);
      step(1'b1, W_B, 32'h44, 1'b0);
      check_out("pre_flush2", 1'b1, 1'b0, W_A, 1'b0, 32'h40);
      flush = 1'b1;
      step(1'b1, W_C, 32'h48, 1'b0);
      check_out("flush2", 1'b0, 1'b1, '0, 1'b0, '0);
      flush = 1'b0;
      step(1'b0, '0, 32'h0, 1'b1);
      check_out("post_flush2", 1'b0, 1'b1, '0, 1'b0, '0);

      // Flush at occupancy 1 drops an accepted same-cycle push
      step(1'b1, W_D, 32'h50, 1'b0);
      check_out("pre_flush1", 1'b1, 1'b1, W_D, 1'b0, 32'h50);
      flush = 1'b1;
      step(1'b1, W_E, 32'h54, 1'b0);
      check_out("flush1", 1'b0, 1'b1, '0, 1'b0, '0);
      flush = 1'b0;
      step(1'b0, '0, 32'h0, 1'b1);
      check_out("post_flush1", 1'b0, 1'b1, '0, 1'b0, '0);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule : tb_if_id_pipe_reg
